pll_lock_ctrl: RTL and testbench

//   Reset/lock sequencer for the main PLL. Pulses the PLL reset, waits for extlock, and debounces lock.

---
 rtl/pll_lock_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and 24 MHz default timing for the PLL reset/lock sequencer.
package pll_lock_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  // Defaults for a 24 MHz reference clock.
  localparam int DEF_RST_CYCLES    = 24;
  localparam int DEF_LOCK_TIMEOUT  = 24000;
  localparam int DEF_STABLE_CYCLES = 240;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_CNT_W         = 16;

  // Width of the retry counter; never narrower than one bit.
  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a debounced lock, releases
// the system reset, retries on timeout and re-sequences when lock is lost.
module pll_lock_ctrl
  import pll_lock_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                                refclk,
  input  logic                                reset,
  input  logic                                extlock,
  input  logic                                restart,
  output logic                                pll_reset,
  output logic                                sys_rst,
  output logic                                ready,
  output logic                                fail,
  output logic                                lock_lost,
  output logic [retry_width(MAX_RETRY)-1:0]   retry_cnt,
  output logic [7:0]                          loss_cnt,
  output logic [2:0]                          state
);

  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .reset (reset),
    .d     (extlock),
    .q     (lock_s)
  );

  pll_state_t       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_n;
  logic [RW-1:0]    retry_n;
  logic [7:0]       loss_n;
  logic             lost_n;
  logic             timeout;

  assign timeout = (to_cnt_q == TO_LAST);
  assign state   = state_q;

  // Next-state logic. to_cnt spans the whole attempt (WAIT_LOCK and STABLE),
  // so a lock that keeps bouncing still runs out of time.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    to_cnt_n = to_cnt_q;
    retry_n  = retry_cnt;
    loss_n   = loss_cnt;
    lost_n   = 1'b0;

    case (state_q)
      RST_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_n  = WAIT_LOCK;
          cnt_n    = '0;
          to_cnt_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        to_cnt_n = to_cnt_q + 1'b1;
        if (lock_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (timeout) begin
          cnt_n = '0;
          if (retry_cnt < RETRY_MAX) begin
            retry_n = retry_cnt + 1'b1;
            state_n = RST_PLL;
          end else begin
            state_n = FAIL;
          end
        end
      end

      STABLE: begin
        to_cnt_n = to_cnt_q + 1'b1;
        if (timeout) begin
          cnt_n = '0;
          if (retry_cnt < RETRY_MAX) begin
            retry_n = retry_cnt + 1'b1;
            state_n = RST_PLL;
          end else begin
            state_n = FAIL;
          end
        end else if (lock_s) begin
          if (cnt_q == STABLE_LAST) begin
            state_n = RUN;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end else begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end

      RUN: begin
        if (!lock_s) begin
          lost_n  = 1'b1;
          loss_n  = (loss_cnt == 8'hff) ? loss_cnt : loss_cnt + 8'd1;
          retry_n = '0;
          cnt_n   = '0;
          state_n = RST_PLL;
        end
      end

      FAIL: begin
        state_n = FAIL;
      end

      default: begin
        state_n = RST_PLL;
        cnt_n   = '0;
      end
    endcase

    // A restart overrides the FSM but leaves any lock-loss bookkeeping intact.
    if (restart) begin
      state_n = RST_PLL;
      cnt_n   = '0;
      retry_n = '0;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q   <= RST_PLL;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      lock_lost <= 1'b0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      to_cnt_q  <= to_cnt_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
      lock_lost <= lost_n;
      pll_reset <= (state_n == RST_PLL) || (state_n == FAIL);
      sys_rst   <= (state_n != RUN);
      ready     <= (state_n == RUN);
      fail      <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters and an expected-value queue.
module tb_pll_lock_ctrl;
  import pll_lock_pkg::*;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;
  localparam int MR    = 2;
  localparam int W     = 16;

  localparam int SEL_READY = 0;
  localparam int SEL_PLL   = 1;
  localparam int SEL_LOST  = 2;
  localparam int SEL_FAIL  = 3;

  logic       refclk = 1'b0;
  logic       reset, extlock, restart;
  logic       pll_reset, sys_rst, ready, fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W-1:0] exp_q[$];

  pll_lock_ctrl #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .MAX_RETRY     (MR),
    .CNT_W         (16)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .extlock   (extlock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  // Clock and reset
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard
  task automatic expect_v(input int v);
    exp_q.push_back(W'(v));
  endtask

  task automatic observe(input string tag, input int got);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d with no expected value queued", tag, got);
    end else begin
      check(tag, got, int'(exp_q.pop_front()));
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_READY: return ready;
      SEL_PLL:   return pll_reset;
      SEL_LOST:  return lock_lost;
      default:   return fail;
    endcase
  endfunction

  // Driver tasks
  task automatic wait_for(input string tag, input int sel, input logic val, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (sig(sel) === val) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_bound"}, 0, 1);
  endtask

  task automatic check_rst(input string p);
    check({p, "_state"}, state, RST_PLL);
    check({p, "_pll_reset"}, pll_reset, 1);
    check({p, "_sys_rst"}, sys_rst, 1);
    check({p, "_ready"}, ready, 0);
    check({p, "_fail"}, fail, 0);
    check({p, "_lock_lost"}, lock_lost, 0);
    check({p, "_retry"}, retry_cnt, 0);
    check({p, "_loss"}, loss_cnt, 0);
  endtask

  task automatic do_reset(input logic lock_val);
    reset   = 1'b1;
    restart = 1'b0;
    extlock = lock_val;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, t0;
    logic ready_seen, prev_pr, prev_fail;

    reset = 1'b1; extlock = 1'b0; restart = 1'b0;

    // Nominal
    do_reset(1'b0);
    check_rst("reset");
    expect_v(RST_C);
    wait_for("nom_pll", SEL_PLL, 1'b0, 50, at);
    observe("nom_pll_pulse", at);
    while (cyc < 9) tick();
    extlock = 1'b1;
    t0 = cyc;
    expect_v(ST_C + 3);
    wait_for("nom_ready", SEL_READY, 1'b1, 100, at);
    observe("nom_lock_lat", at - t0);
    check("nom_sys_rst", sys_rst, 0);
    check("nom_retry", retry_cnt, 0);
    check("nom_state", state, RUN);

    // Lock loss in RUN, then relock
    extlock = 1'b0;
    t0 = cyc;
    expect_v(3);
    wait_for("loss", SEL_LOST, 1'b1, 20, at);
    observe("loss_lat", at - t0);
    check("loss_sys_rst", sys_rst, 1);
    check("loss_cnt1", loss_cnt, 1);
    check("loss_state", state, RST_PLL);
    extlock = 1'b1;
    t0 = cyc;
    tick();
    check("loss_pulse_width", lock_lost, 0);
    expect_v(RST_C + 1 + ST_C);
    wait_for("relock", SEL_READY, 1'b1, 100, at);
    observe("relock_lat", at - t0);
    check("relock_loss_cnt", loss_cnt, 1);

    // Restart on the same edge as a lock loss
    extlock = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_loss_pulse", lock_lost, 1);
    check("rs_loss_cnt", loss_cnt, 2);
    check("rs_state", state, RST_PLL);
    check("rs_retry", retry_cnt, 0);

    // Restart together with reset
    reset = 1'b1;
    restart = 1'b1;
    tick();
    check_rst("rst_restart");
    reset = 1'b0;
    restart = 1'b0;

    // Glitch on extlock
    do_reset(1'b0);
    ready_seen = 1'b0;
    while (cyc < 10) begin
      if (cyc == 2) extlock = 1'b1;
      if (cyc == 7) extlock = 1'b0;
      if (cyc == 9) extlock = 1'b1;
      tick();
      if (ready) ready_seen = 1'b1;
      if (cyc == 5) check("glitch_stable", state, STABLE);
    end
    check("glitch_no_run", ready_seen, 0);
    check("glitch_wait", state, WAIT_LOCK);
    expect_v(ST_C + 3);
    wait_for("glitch_ready", SEL_READY, 1'b1, 100, at);
    observe("glitch_lat", at - 9);

    // Reset in the middle of STABLE
    do_reset(1'b1);
    while (cyc < 10) tick();
    check("mid_stable", state, STABLE);
    reset = 1'b1;
    tick();
    check_rst("mid_rst");
    reset = 1'b0;
    cyc = 0;
    expect_v(RST_C);
    expect_v(RST_C + 1 + ST_C);
    wait_for("mid_pll", SEL_PLL, 1'b0, 50, at);
    observe("mid_pll_pulse", at);
    wait_for("mid_ready", SEL_READY, 1'b1, 100, at);
    observe("mid_ready_lat", at);

    // No lock: retries then FAIL
    do_reset(1'b0);
    for (int a = 0; a <= MR; a++) begin
      expect_v(a * (RST_C + TO_C) + RST_C);
      if (a < MR) begin
        expect_v((a + 1) * (RST_C + TO_C));
        expect_v(a + 1);
      end
    end
    expect_v((1 + MR) * (RST_C + TO_C));
    expect_v((1 + MR) * (RST_C + TO_C));
    expect_v(MR);
    prev_pr = pll_reset;
    prev_fail = fail;
    while (cyc < (1 + MR) * (RST_C + TO_C) + 10) begin
      tick();
      if (pll_reset !== prev_pr) begin
        observe("nolock_pll_edge", cyc);
        if (pll_reset && !fail) observe("nolock_retry", retry_cnt);
      end
      if (fail && !prev_fail) begin
        observe("nolock_fail_at", cyc);
        observe("nolock_fail_retry", retry_cnt);
      end
      prev_pr = pll_reset;
      prev_fail = fail;
    end
    check("nolock_fail_held", fail, 1);
    check("nolock_pll_held", pll_reset, 1);

    // Restart from FAIL
    restart = 1'b1;
    tick();
    restart = 1'b0;
    t0 = cyc;
    check("restart_fail", fail, 0);
    check("restart_retry", retry_cnt, 0);
    check("restart_state", state, RST_PLL);
    check("restart_pll", pll_reset, 1);
    expect_v(RST_C);
    wait_for("restart_pll", SEL_PLL, 1'b0, 50, at);
    observe("restart_pulse", at - t0);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: %0d expected values never observed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
